holy_axi_ram_slave: RTL and testbench
=====================================

// Module: holy_axi_ram_slave
// PURPOSE
//   AXI4 full-protocol responder backed by on-chip word RAM: the slave end of the core's AXI master.
//   Replaces the cocotb-simulated RAM in standalone benches and small SoC builds.
//   Independent read and write FSMs, one outstanding transaction per direction, INCR and FIXED bursts.
// PARAMETERS
//   ID_WIDTH     4        width of awid/bid/arid/rid
//   DEPTH_WORDS  1024     RAM size in 32-bit words (power of two)
//   BASE_ADDR    32'h0    byte address mapped to word 0
// PORTS
//   clk            in   1    single clock for all logic
//   rst            in   1    reset, synchronous, active-high
//   s_axi_awid     in   ID   write burst ID
//   s_axi_awaddr   in   32   write start byte address
//   s_axi_awlen    in   8    beats-1
//   s_axi_awsize   in   3    must be 3'b010
//   s_axi_awburst  in   2    00 FIXED, 01 INCR, other -> error
//   s_axi_awvalid/awready  in/out 1  AW handshake
//   s_axi_wdata    in   32   write data
//   s_axi_wstrb    in   4    byte enables
//   s_axi_wlast    in   1    last write beat
//   s_axi_wvalid/wready    in/out 1  W handshake
//   s_axi_bid      out  ID   = captured awid
//   s_axi_bresp    out  2    00 OKAY, 10 SLVERR
//   s_axi_bvalid/bready    out/in 1  B handshake
//   s_axi_arid, araddr, arlen, arsize, arburst  in  ID/32/8/3/2  read burst request
//   s_axi_arvalid/arready  in/out 1  AR handshake
//   s_axi_rid      out  ID   = captured arid
//   s_axi_rdata    out  32   read data
//   s_axi_rresp    out  2    00 OKAY, 10 SLVERR
//   s_axi_rlast    out  1    final beat
//   s_axi_rvalid/rready    out/in 1  R handshake
// BEHAVIOUR
//   Reset: awready=arready=1, wready=bvalid=rvalid=rlast=0, bresp=rresp=00, bid=rid=rdata=0; both FSMs IDLE.
//   Reset mid-burst aborts both FSMs to IDLE; RAM contents are NOT cleared.
//   Word index = (addr-BASE_ADDR)>>2; in range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS. addr[1:0] ignored.
//   Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//     W_IDLE: awready=1; on AW handshake capture id/addr/len/burst, beat count=0, err=0, go W_DATA.
//     W_DATA: wready=1; each W handshake writes bytes with wstrb=1 to current word (same cycle, visible next cycle).
//       INCR: address +4 per beat, 32-bit wrap; FIXED: address held.
//       Out-of-range beat: not written, err=1. Beat count > awlen: not written, err=1.
//       wlast on beat count != awlen: err=1. Leave W_DATA only on beat with wlast=1.
//     W_RESP: bvalid=1, bresp = err?10:00; hold until bready; then W_IDLE (awready=1 next cycle).
//     Bad awsize/awburst at AW: err=1, every beat dropped, burst still fully consumed.
//   Read FSM R_IDLE -> R_DATA -> R_IDLE:
//     R_IDLE: arready=1; on AR handshake capture, go R_DATA; rvalid first high cycle after handshake.
//     R_DATA: rdata = RAM[current index] (combinational array read); rlast=1 when beat count == arlen.
//       rdata/rresp/rlast stable while rvalid && !rready. On handshake advance index (INCR/FIXED as write).
//       Out-of-range or bad size/burst beat: rdata=0, rresp=10. Back-to-back beats at 1/cycle with rready=1.
//       Handshake on rlast beat -> R_IDLE, rvalid=0 next cycle.
//   Minimum latencies: AR handshake -> first rvalid 1 cycle; last W beat -> bvalid 1 cycle.
//   Read and write fully concurrent. Same-cycle write and read of one word: read returns OLD data.
//   awlen=0 / arlen=0 single-beat bursts legal; 256-beat bursts supported (8-bit counters, no overflow).
// TESTING
//   INCR write awaddr=0x100 awlen=3 data 0xA0..0xA3, wstrb=F -> bresp=00, bid=awid; read back 4 beats, rlast on beat 3.
//   Write 0xDEADBEEF to 0x40, then wstrb=4'b0010 data 0x00001200 -> read 0x40 returns 0xDEADBEEF with byte1=0x12 -> 0xDEAD12EF.
//   Read arlen=7 with rready toggled 1/0 each cycle -> rdata held stable during stalls, 8 beats, correct sequence.
//   Write crossing end (DEPTH=1024, awaddr=0xFFC, awlen=1) -> word 1023 written, second beat dropped, bresp=10.
//   wlast asserted on beat 1 of awlen=3 -> burst ends, bresp=10; awburst=10 (WRAP) -> no RAM change, bresp=10.
//   Assert rst during R_DATA beat 2 -> next cycle rvalid=0, arready=1; new read returns previously written data.

Source files
------------

// File: rtl/holy_axi_ram_slave.sv
// AXI4 slave backed by an on-chip 32-bit word RAM.
// Independent read/write FSMs, one outstanding burst per direction, INCR and FIXED bursts.
module holy_axi_ram_slave #(
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_WIDTH-1:0] s_axi_awid,
    input  logic [31:0]         s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_WIDTH-1:0] s_axi_arid,
    input  logic [31:0]         s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_WIDTH-1:0] s_axi_rid,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic in_range(input logic [31:0] a);
        return (a - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[IDX_W+1:2];
    endfunction

    // ---------------- write channel ----------------
    w_state_t            w_state, w_state_d;
    logic [ID_WIDTH-1:0] aw_id, aw_id_d;
    logic [31:0]         aw_addr, aw_addr_d;
    logic [7:0]          aw_len, aw_len_d;
    logic                aw_bad, aw_bad_d, aw_fixed, aw_fixed_d;
    logic [8:0]          w_cnt, w_cnt_d;   // saturates at 256 so overlong bursts stay flagged
    logic                w_err, w_err_d;
    logic                mem_we, w_beat_ok;

    always_comb begin
        w_state_d  = w_state;
        aw_id_d    = aw_id;
        aw_addr_d  = aw_addr;
        aw_len_d   = aw_len;
        aw_bad_d   = aw_bad;
        aw_fixed_d = aw_fixed;
        w_cnt_d    = w_cnt;
        w_err_d    = w_err;
        mem_we     = 1'b0;
        w_beat_ok  = in_range(aw_addr) && !aw_bad && (w_cnt <= {1'b0, aw_len});
        case (w_state)
            W_IDLE: if (s_axi_awvalid) begin
                aw_id_d    = s_axi_awid;
                aw_addr_d  = s_axi_awaddr;
                aw_len_d   = s_axi_awlen;
                aw_bad_d   = (s_axi_awsize != 3'b010) || s_axi_awburst[1];
                aw_fixed_d = (s_axi_awburst == 2'b00);
                w_cnt_d    = 9'd0;
                w_err_d    = (s_axi_awsize != 3'b010) || s_axi_awburst[1];
                w_state_d  = W_DATA;
            end
            W_DATA: if (s_axi_wvalid) begin
                mem_we = w_beat_ok;
                if (!w_beat_ok || (s_axi_wlast && (w_cnt != {1'b0, aw_len})))
                    w_err_d = 1'b1;
                if (w_cnt != 9'd256)
                    w_cnt_d = w_cnt + 9'd1;
                if (!aw_fixed)
                    aw_addr_d = aw_addr + 32'd4;
                if (s_axi_wlast)
                    w_state_d = W_RESP;
            end
            W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state  <= W_IDLE;
            aw_id    <= '0;
            aw_addr  <= '0;
            aw_len   <= '0;
            aw_bad   <= 1'b0;
            aw_fixed <= 1'b0;
            w_cnt    <= '0;
            w_err    <= 1'b0;
        end else begin
            w_state  <= w_state_d;
            aw_id    <= aw_id_d;
            aw_addr  <= aw_addr_d;
            aw_len   <= aw_len_d;
            aw_bad   <= aw_bad_d;
            aw_fixed <= aw_fixed_d;
            w_cnt    <= w_cnt_d;
            w_err    <= w_err_d;
        end
    end

    // RAM is never reset; contents survive a reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_we && !rst && s_axi_wstrb[b])
                mem[word_idx(aw_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end

    assign s_axi_awready = (w_state == W_IDLE);
    assign s_axi_wready  = (w_state == W_DATA);
    assign s_axi_bvalid  = (w_state == W_RESP);
    assign s_axi_bresp   = (w_state == W_RESP && w_err) ? 2'b10 : 2'b00;
    assign s_axi_bid     = aw_id;

    // ---------------- read channel ----------------
    r_state_t            r_state, r_state_d;
    logic [ID_WIDTH-1:0] ar_id, ar_id_d;
    logic [31:0]         ar_addr, ar_addr_d;
    logic [7:0]          ar_len, ar_len_d, r_cnt, r_cnt_d;
    logic                ar_bad, ar_bad_d, ar_fixed, ar_fixed_d;
    logic                r_ok, r_last;

    always_comb begin
        r_state_d  = r_state;
        ar_id_d    = ar_id;
        ar_addr_d  = ar_addr;
        ar_len_d   = ar_len;
        ar_bad_d   = ar_bad;
        ar_fixed_d = ar_fixed;
        r_cnt_d    = r_cnt;
        r_last     = (r_cnt == ar_len);
        case (r_state)
            R_IDLE: if (s_axi_arvalid) begin
                ar_id_d    = s_axi_arid;
                ar_addr_d  = s_axi_araddr;
                ar_len_d   = s_axi_arlen;
                ar_bad_d   = (s_axi_arsize != 3'b010) || s_axi_arburst[1];
                ar_fixed_d = (s_axi_arburst == 2'b00);
                r_cnt_d    = 8'd0;
                r_state_d  = R_DATA;
            end
            R_DATA: if (s_axi_rready) begin
                if (r_last) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_cnt_d = r_cnt + 8'd1;
                    if (!ar_fixed)
                        ar_addr_d = ar_addr + 32'd4;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            ar_id    <= '0;
            ar_addr  <= '0;
            ar_len   <= '0;
            ar_bad   <= 1'b0;
            ar_fixed <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= r_state_d;
            ar_id    <= ar_id_d;
            ar_addr  <= ar_addr_d;
            ar_len   <= ar_len_d;
            ar_bad   <= ar_bad_d;
            ar_fixed <= ar_fixed_d;
            r_cnt    <= r_cnt_d;
        end
    end

    // Read data comes straight from the array so a same-cycle write is not yet visible.
    assign r_ok          = in_range(ar_addr) && !ar_bad;
    assign s_axi_arready = (r_state == R_IDLE);
    assign s_axi_rvalid  = (r_state == R_DATA);
    assign s_axi_rlast   = (r_state == R_DATA) && r_last;
    assign s_axi_rdata   = (r_state == R_DATA && r_ok) ? mem[word_idx(ar_addr)] : 32'h0;
    assign s_axi_rresp   = (r_state == R_DATA && !r_ok) ? 2'b10 : 2'b00;
    assign s_axi_rid     = ar_id;
endmodule

// File: tb/tb_holy_axi_ram_slave.sv
// Directed bench for holy_axi_ram_slave: bursts, strobes, stalls, range errors and reset.
module tb_holy_axi_ram_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
    logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
    logic [7:0]  s_axi_awlen, s_axi_arlen;
    logic [2:0]  s_axi_awsize, s_axi_arsize;
    logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

    holy_axi_ram_slave #(.ID_WIDTH(4), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd [16];
    logic [1:0]  rr [16];
    logic        rl [16];
    logic [1:0]  bresp_got;
    logic [3:0]  bid_got;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awburst = burst; s_axi_awsize = size; s_axi_awvalid = 1'b1;
        while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
        check("aw_ready", 32'(s_axi_awready), 32'd1);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int n = 0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arburst = burst; s_axi_arsize = 3'b010; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
        check("ar_ready", 32'(s_axi_arready), 32'd1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        check("r_latency", 32'(s_axi_rvalid), 32'd1);
        check("rid", 32'(s_axi_rid), 32'(id));
    endtask

    // Sends beats 0..last_at from wd/ws, wlast on beat last_at, then takes the B response.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int last_at);
        int n;
        send_aw(id, addr, len, burst, 3'b010);
        for (int i = 0; i <= last_at; i++) begin
            s_axi_wdata = wd[i]; s_axi_wstrb = ws[i];
            s_axi_wlast = (i == last_at); s_axi_wvalid = 1'b1;
            n = 0;
            while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
            @(negedge clk);
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        check("b_latency", 32'(s_axi_bvalid), 32'd1);
        bresp_got = s_axi_bresp; bid_got = s_axi_bid;
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check("aw_ready_after_b", 32'(s_axi_awready), 32'd1);
    endtask

    // Collects len+1 beats into rd/rr/rl; with toggle, rready alternates and stalls are checked.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic toggle);
        int beat = 0;
        int cyc  = 0;
        logic        hold_v = 1'b0;
        logic [31:0] held   = '0;
        send_ar(id, addr, len, burst);
        while (beat <= int'(len) && cyc < 400) begin
            s_axi_rready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (s_axi_rvalid) begin
                if (hold_v) begin
                    check("r_stable", s_axi_rdata, held);
                    hold_v = 1'b0;
                end
                if (s_axi_rready) begin
                    rd[beat] = s_axi_rdata; rr[beat] = s_axi_rresp; rl[beat] = s_axi_rlast;
                    beat++;
                end else begin
                    held = s_axi_rdata; hold_v = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        s_axi_rready = 1'b0;
        check("r_beats", 32'(beat), 32'(len) + 32'd1);
        check("r_idle", 32'(s_axi_rvalid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'b010;
        s_axi_awburst = 2'b01; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'b010;
        s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(s_axi_awready), 32'd1);
        check("rst_arready", 32'(s_axi_arready), 32'd1);
        check("rst_wready",  32'(s_axi_wready),  32'd0);
        check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
        check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
        check("rst_rlast",   32'(s_axi_rlast),   32'd0);
        check("rst_resp",    32'({s_axi_bresp, s_axi_rresp}), 32'd0);
        check("rst_ids",     32'({s_axi_bid, s_axi_rid}), 32'd0);
        check("rst_rdata",   s_axi_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // INCR 4-beat write and readback
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        do_write(4'd5, 32'h100, 8'd3, 2'b01, 3);
        check("incr_bresp", 32'(bresp_got), 32'd0);
        check("incr_bid", 32'(bid_got), 32'd5);
        do_read(4'd9, 32'h100, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("incr_rdata", rd[i], 32'hA0 + 32'(i));
            check("incr_rresp", 32'(rr[i]), 32'd0);
            check("incr_rlast", 32'(rl[i]), (i == 3) ? 32'd1 : 32'd0);
        end

        // Byte strobe merge
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(4'd1, 32'h40, 8'd0, 2'b01, 0);
        wd[0] = 32'h00001200; ws[0] = 4'b0010;
        do_write(4'd1, 32'h40, 8'd0, 2'b01, 0);
        check("strb_bresp", 32'(bresp_got), 32'd0);
        do_read(4'd2, 32'h40, 8'd0, 2'b01, 1'b0);
        check("strb_rdata", rd[0], 32'hDEAD12EF);
        check("strb_rlast", 32'(rl[0]), 32'd1);

        // 8-beat read with rready toggling
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + 32'(i); ws[i] = 4'hF; end
        do_write(4'd3, 32'h110, 8'd3, 2'b01, 3);
        do_read(4'd4, 32'h100, 8'd7, 2'b01, 1'b1);
        for (int i = 0; i < 8; i++)
            check("stall_rdata", rd[i], (i < 4) ? 32'hA0 + 32'(i) : 32'hB0 + 32'(i - 4));
        check("stall_rlast7", 32'(rl[7]), 32'd1);
        check("stall_rlast6", 32'(rl[6]), 32'd0);

        // Burst crossing the end of RAM
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'd6, 32'hFFC, 8'd1, 2'b01, 1);
        check("end_bresp", 32'(bresp_got), 32'd2);
        do_read(4'd6, 32'hFFC, 8'd0, 2'b01, 1'b0);
        check("end_rdata", rd[0], 32'h11111111);
        check("end_rresp", 32'(rr[0]), 32'd0);
        do_read(4'd6, 32'h1000, 8'd0, 2'b01, 1'b0);
        check("oor_rdata", rd[0], 32'h0);
        check("oor_rresp", 32'(rr[0]), 32'd2);

        // Early wlast, then WRAP burst rejected
        wd[0] = 32'hC0; wd[1] = 32'hC1; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'd7, 32'h200, 8'd3, 2'b01, 1);
        check("early_wlast_bresp", 32'(bresp_got), 32'd2);
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        do_write(4'd7, 32'h200, 8'd0, 2'b10, 0);
        check("wrap_bresp", 32'(bresp_got), 32'd2);
        do_read(4'd7, 32'h200, 8'd1, 2'b01, 1'b0);
        check("wrap_keep0", rd[0], 32'hC0);
        check("wrap_keep1", rd[1], 32'hC1);

        // FIXED bursts hold the address
        wd[0] = 32'h1; wd[1] = 32'h2; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'd8, 32'h300, 8'd1, 2'b00, 1);
        check("fixed_bresp", 32'(bresp_got), 32'd0);
        do_read(4'd8, 32'h300, 8'd0, 2'b01, 1'b0);
        check("fixed_wdata", rd[0], 32'h2);
        do_read(4'd8, 32'h100, 8'd1, 2'b00, 1'b0);
        check("fixed_r0", rd[0], 32'hA0);
        check("fixed_r1", rd[1], 32'hA0);

        // Reset in the middle of a read burst
        send_ar(4'd3, 32'h100, 8'd7, 2'b01);
        s_axi_rready = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rdata2", s_axi_rdata, 32'hA2);
        s_axi_rready = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("mid_rst_arready", 32'(s_axi_arready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        do_read(4'd2, 32'h100, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++)
            check("post_rst_rdata", rd[i], 32'hA0 + 32'(i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
